// File: rtl/mmio_timer_uart_port_if.sv
// rtl/mmio_timer_uart_port_if.sv - data-bus and TX byte-stream bundle for mmio_timer_uart_port
interface mmio_timer_uart_port_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic        bus_wr_en;
    logic [31:0] bus_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output bus_addr, bus_wr_data, bus_wr_en, tx_ready,
        input  bus_rd_data, tx_data, tx_valid
    );

    modport slave (
        input  bus_addr, bus_wr_data, bus_wr_en, tx_ready,
        output bus_rd_data, tx_data, tx_valid
    );
endinterface

// File: rtl/mmio_timer_uart_port.sv
// rtl/mmio_timer_uart_port.sv - MMIO cycle counter, compare timer with irq, and TX byte FIFO
// Optional TXDROP counter at offset 6 is built when MMIO_TX_DROP_CNT_EN is defined.
module mmio_timer_uart_port #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_timer_uart_port_if.slave  bus,
    output logic                   irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OFF_CYCLE  = 3'd0;
    localparam logic [2:0] OFF_TCMP   = 3'd1;
    localparam logic [2:0] OFF_TCTRL  = 3'd2;
    localparam logic [2:0] OFF_TCNT   = 3'd3;
    localparam logic [2:0] OFF_TXDATA = 3'd4;
    localparam logic [2:0] OFF_TXSTAT = 3'd5;
    localparam logic [2:0] OFF_TXDROP = 3'd6;

    logic        hit, wr;
    logic [2:0]  off;
    logic        unused_addr_lsb;

    assign hit             = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign off             = bus.bus_addr[4:2];
    assign wr              = bus.bus_wr_en & hit;
    assign unused_addr_lsb = ^bus.bus_addr[1:0];

    logic [31:0] cycle_q, cycle_d, tcmp_q, tcmp_d, tcnt_q, tcnt_d;
    logic        ten_q, ten_d, ien_q, ien_d, pend_q, pend_d, irq_q, irq_d;
    logic        match;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, pop, push_req, push_ok;

    assign match    = ten_q && (tcnt_q == tcmp_q);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = wr && (off == OFF_TXDATA);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop);

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign irq          = irq_q;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        tcmp_d  = tcmp_q;
        ten_d   = ten_q;
        ien_d   = ien_q;
        pend_d  = pend_q;
        tcnt_d  = tcnt_q;
        if (wr && off == OFF_TCMP) tcmp_d = bus.bus_wr_data;
        if (wr && off == OFF_TCTRL) begin
            ten_d = bus.bus_wr_data[0];
            ien_d = bus.bus_wr_data[1];
            if (bus.bus_wr_data[2]) pend_d = 1'b0;
        end
        // Match sets PEND after the W1C so a same-cycle clear loses.
        if (match) pend_d = 1'b1;
        if (wr && off == OFF_TCNT) tcnt_d = bus.bus_wr_data;
        else if (match)            tcnt_d = 32'd0;
        else if (ten_q)            tcnt_d = tcnt_q + 32'd1;
        irq_d = pend_q & ien_q;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.bus_wr_data[7:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef MMIO_TX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (wr && off == OFF_TXDROP)                  drop_cnt_d = 16'd0;
        else if (push_req && !push_ok && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= 16'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end
`endif

    always_comb begin
        bus.bus_rd_data = 32'd0;
        if (hit) begin
            case (off)
                OFF_CYCLE:  bus.bus_rd_data = cycle_q;
                OFF_TCMP:   bus.bus_rd_data = tcmp_q;
                OFF_TCTRL:  bus.bus_rd_data = {29'd0, pend_q, ien_q, ten_q};
                OFF_TCNT:   bus.bus_rd_data = tcnt_q;
                OFF_TXSTAT: bus.bus_rd_data = {21'd0, empty, full, 9'(count_q)};
`ifdef MMIO_TX_DROP_CNT_EN
                OFF_TXDROP: bus.bus_rd_data = {16'd0, drop_cnt_q};
`endif
                default:    bus.bus_rd_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= 32'd0;
            tcmp_q   <= 32'd0;
            ten_q    <= 1'b0;
            ien_q    <= 1'b0;
            pend_q   <= 1'b0;
            tcnt_q   <= 32'd0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            cycle_q  <= cycle_d;
            tcmp_q   <= tcmp_d;
            ten_q    <= ten_d;
            ien_q    <= ien_d;
            pend_q   <= pend_d;
            tcnt_q   <= tcnt_d;
            irq_q    <= irq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates everything that reads it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_mmio_timer_uart_port.sv
// tb/tb_mmio_timer_uart_port.sv - directed self-checking bench for mmio_timer_uart_port
module tb_mmio_timer_uart_port;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mmio_timer_uart_port_if intf ();

    mmio_timer_uart_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [2:0]  off;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        intf.bus_addr    = addr;
        intf.bus_wr_data = data;
        intf.bus_wr_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        intf.bus_wr_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        intf.bus_addr = addr;
        #1;
        data = intf.bus_rd_data;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 3'd1, 32'h1234_5678};
        vecs[1]  = '{1'b0, 3'd1, 32'h1234_5678};
        vecs[2]  = '{1'b1, 3'd3, 32'h0000_0077};
        vecs[3]  = '{1'b0, 3'd3, 32'h0000_0077};
        vecs[4]  = '{1'b1, 3'd2, 32'hFFFF_FFFA};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0002};
        vecs[6]  = '{1'b1, 3'd2, 32'h0000_0000};
        vecs[7]  = '{1'b0, 3'd2, 32'h0000_0000};
        vecs[8]  = '{1'b0, 3'd4, 32'h0000_0000};
        vecs[9]  = '{1'b0, 3'd5, 32'h0000_0400};
        vecs[10] = '{1'b0, 3'd6, 32'h0000_0000};
        vecs[11] = '{1'b0, 3'd7, 32'h0000_0000};
        vecs[12] = '{1'b1, 3'd3, 32'h0000_0000};
        vecs[13] = '{1'b0, 3'd3, 32'h0000_0000};
        vecs[14] = '{1'b1, 3'd1, 32'h0000_0000};

        reset            = 1'b1;
        intf.bus_addr    = BASE;
        intf.bus_wr_data = 32'd0;
        intf.bus_wr_en   = 1'b0;
        intf.tx_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tx_valid", {31'd0, intf.tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, intf.tx_data}, 32'd0);
        bus_read(BASE + 32'h14, rd);
        check("reset_txstat", rd, 32'h400);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus_read(BASE, rd);
        check("cycle_after_10", rd, 32'd10);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(BASE + {27'd0, vecs[i].off, 2'b00}, vecs[i].data);
            end else begin
                bus_read(BASE + {27'd0, vecs[i].off, 2'b00}, rd);
                check($sformatf("vec%0d_off%0d", i, vecs[i].off), rd, vecs[i].data);
            end
        end

        bus_write(BASE + 32'h04, 32'd4);
        bus_write(BASE + 32'h08, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            step();
            bus_read(BASE + 32'h0C, rd);
            check($sformatf("tcnt_run%0d", k), rd, k);
            bus_read(BASE + 32'h08, rd);
            check($sformatf("tctrl_run%0d", k), rd, 32'h3);
        end
        step();
        bus_read(BASE + 32'h0C, rd);
        check("tcnt_reload", rd, 32'd0);
        bus_read(BASE + 32'h08, rd);
        check("pend_set", rd, 32'h7);
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        step();
        check("irq_high", {31'd0, irq}, 32'd1);

        bus_write(BASE + 32'h08, 32'h7);
        bus_read(BASE + 32'h08, rd);
        check("pend_w1c", rd, 32'h3);
        check("irq_lag", {31'd0, irq}, 32'd1);
        step();
        check("irq_low", {31'd0, irq}, 32'd0);
        step();
        bus_read(BASE + 32'h0C, rd);
        check("tcnt_at_match", rd, 32'd4);
        bus_write(BASE + 32'h08, 32'h7);
        bus_read(BASE + 32'h08, rd);
        check("pend_beats_w1c", rd, 32'h7);
        bus_read(BASE + 32'h0C, rd);
        check("tcnt_match_w1c", rd, 32'd0);
        bus_write(BASE + 32'h08, 32'h4);
        bus_read(BASE + 32'h08, rd);
        check("timer_off", rd, 32'h0);

        intf.tx_ready = 1'b0;
        check("fifo_idle_valid", {31'd0, intf.tx_valid}, 32'd0);
        for (int b = 1; b <= 17; b++) begin
            bus_write(BASE + 32'h10, b);
            if (b == 1) begin
                check("first_push_valid", {31'd0, intf.tx_valid}, 32'd1);
                check("first_push_data", {24'd0, intf.tx_data}, 32'h01);
            end
        end
        bus_read(BASE + 32'h14, rd);
        check("txstat_full", rd, 32'h210);
`ifdef MMIO_TX_DROP_CNT_EN
        bus_read(BASE + 32'h18, rd);
        check("txdrop_one", rd, 32'd1);
        bus_write(BASE + 32'h18, 32'd0);
        bus_read(BASE + 32'h18, rd);
        check("txdrop_clear", rd, 32'd0);
`endif

        intf.tx_ready = 1'b1;
        bus_write(BASE + 32'h10, 32'hAA);
        intf.tx_ready = 1'b0;
        bus_read(BASE + 32'h14, rd);
        check("full_push_pop_occ", rd, 32'h210);
        check("full_push_pop_head", {24'd0, intf.tx_data}, 32'h02);

        intf.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid%0d", i), {31'd0, intf.tx_valid}, 32'd1);
            check($sformatf("drain_data%0d", i), {24'd0, intf.tx_data},
                  (i < 15) ? (i + 2) : 32'hAA);
            step();
        end
        check("drain_done_valid", {31'd0, intf.tx_valid}, 32'd0);
        intf.tx_ready = 1'b0;
        bus_read(BASE + 32'h14, rd);
        check("drain_txstat", rd, 32'h400);

        bus_write(BASE + 32'h24, 32'hDEAD_BEEF);
        bus_write(BASE - 32'd4, 32'hDEAD_BEEF);
        bus_read(BASE + 32'h24, rd);
        check("miss_hi_read", rd, 32'd0);
        bus_read(BASE - 32'd4, rd);
        check("miss_lo_read", rd, 32'd0);
        bus_read(BASE + 32'h04, rd);
        check("miss_tcmp_kept", rd, 32'd4);

        for (int b = 0; b < 5; b++) bus_write(BASE + 32'h10, 32'h30 + b);
        bus_read(BASE + 32'h14, rd);
        check("five_queued", rd, 32'h005);
        reset = 1'b1;
        step();
        check("reset_mid_valid", {31'd0, intf.tx_valid}, 32'd0);
        bus_read(BASE + 32'h14, rd);
        check("reset_mid_txstat", rd, 32'h400);
        reset = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
